// File: rtl/mon_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for Montgomery exponentiation.
// Drives one shared Montgomery multiplier through a valid/valid handshake.
module mon_exp_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int EXP_WIDTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [EXP_WIDTH-1:0]  exponent,
    input  logic [DATA_WIDTH-1:0] base_mont,
    input  logic [DATA_WIDTH-1:0] one_mont,
    input  logic [DATA_WIDTH-1:0] modulus,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] mp_opA,
    output logic [DATA_WIDTH-1:0] mp_opB,
    output logic [DATA_WIDTH-1:0] mp_opM,
    output logic                  mp_in_valid,
    input  logic [DATA_WIDTH-1:0] mp_out_data,
    input  logic                  mp_out_valid
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE, DRAIN
    } state_t;

    state_t                state;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [IDX_W-1:0]      idx;

    // mp_opM doubles as the captured modulus register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            exp_q       <= '0;
            base_q      <= '0;
            acc         <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            result      <= '0;
            mp_opA      <= '0;
            mp_opB      <= '0;
            mp_opM      <= '0;
            mp_in_valid <= 1'b0;
        end else begin
            mp_in_valid <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q  <= exponent;
                        base_q <= base_mont;
                        mp_opM <= modulus;
                        acc    <= one_mont;
                        idx    <= IDX_W'(EXP_WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= SQ_ISSUE;
                    end
                end
                SQ_ISSUE, MUL_ISSUE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        mp_opA      <= acc;
                        mp_opB      <= (state == SQ_ISSUE) ? acc : base_q;
                        mp_in_valid <= 1'b1;
                        state       <= (state == SQ_ISSUE) ? SQ_WAIT : MUL_WAIT;
                    end
                end
                SQ_WAIT, MUL_WAIT: begin
                    if (abort) begin
                        // A response arriving with the abort is already drained.
                        if (mp_out_valid) begin
                            aborted <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mp_out_valid) begin
                        acc <= mp_out_data;
                        if (state == SQ_WAIT && exp_q[idx]) begin
                            state <= MUL_ISSUE;
                        end else if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQ_ISSUE;
                        end
                    end
                end
                DONE: begin
                    // Nothing is outstanding here, so completion wins over abort.
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                DRAIN: begin
                    if (mp_out_valid) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Bench for mon_exp_ctrl: M=13, R=16, 4-bit data; one instance with a 4-bit
// exponent and one with a 2-bit exponent, sharing one multiplier model.
module tb_mon_exp_ctrl;

    localparam int DW   = 4;
    localparam int L    = 3;   // request occupies L cycles, mp_in_valid..mp_out_valid inclusive
    localparam int MODV = 13;
    localparam int RINV = 9;   // 16*9 = 144 = 1 mod 13

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0, sel = 1'b0, spur = 1'b0;
    logic [3:0]    exponent = '0;
    logic [DW-1:0] base_mont = '0, one_mont = '0, modulus = '0;
    logic          mov;
    logic [DW-1:0] mod_data;
    logic          mp_out_valid;
    logic [DW-1:0] mp_out_data;

    assign mp_out_valid = mov | spur;
    assign mp_out_data  = spur ? 4'hF : mod_data;

    logic          busy_4, done_4, ab_4, inv_4, busy_2, done_2, ab_2, inv_2;
    logic [DW-1:0] res_4, opA_4, opB_4, opM_4, res_2, opA_2, opB_2, opM_2;

    mon_exp_ctrl #(.DATA_WIDTH(DW), .EXP_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .exponent(exponent), .base_mont(base_mont), .one_mont(one_mont),
        .modulus(modulus), .busy(busy_4), .done(done_4), .aborted(ab_4),
        .result(res_4), .mp_opA(opA_4), .mp_opB(opB_4), .mp_opM(opM_4),
        .mp_in_valid(inv_4), .mp_out_data(mp_out_data),
        .mp_out_valid(mp_out_valid & ~sel)
    );

    mon_exp_ctrl #(.DATA_WIDTH(DW), .EXP_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .exponent(exponent[1:0]), .base_mont(base_mont), .one_mont(one_mont),
        .modulus(modulus), .busy(busy_2), .done(done_2), .aborted(ab_2),
        .result(res_2), .mp_opA(opA_2), .mp_opB(opB_2), .mp_opM(opM_2),
        .mp_in_valid(inv_2), .mp_out_data(mp_out_data),
        .mp_out_valid(mp_out_valid & sel)
    );

    logic          busy, done, aborted, mp_in_valid;
    logic [DW-1:0] result, mp_opA, mp_opB, mp_opM;
    assign busy        = sel ? busy_2 : busy_4;
    assign done        = sel ? done_2 : done_4;
    assign aborted     = sel ? ab_2   : ab_4;
    assign mp_in_valid = sel ? inv_2  : inv_4;
    assign result      = sel ? res_2  : res_4;
    assign mp_opA      = sel ? opA_2  : opA_4;
    assign mp_opB      = sel ? opB_2  : opB_4;
    assign mp_opM      = sel ? opM_2  : opM_4;

    // Montgomery multiplier model: a*b*R^-1 mod M, valid L-1 cycles after the request.
    int            mm_cnt;
    logic [DW-1:0] mm_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mov <= 1'b0; mod_data <= '0; mm_cnt <= 0; mm_res <= '0;
        end else begin
            mov <= 1'b0;
            if (mp_in_valid) begin
                mm_res <= 4'((int'(mp_opA) * int'(mp_opB) * RINV) % MODV);
                mm_cnt <= L - 2;
            end else if (mm_cnt == 1) begin
                mov <= 1'b1; mod_data <= mm_res; mm_cnt <= 0;
            end else if (mm_cnt > 1) begin
                mm_cnt <= mm_cnt - 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_mul; int a; int b; } txn_t;
    txn_t exp_q[$];
    txn_t t;
    int exp_res = 0, exp_lat = 0, exp_end = 0, n_issued = 0, start_cyc = 0;
    int last_mov_cyc = 0, last_lat = 0, end_seen = 0;
    int prev_res[2] = '{0, 0};
    int checks = 0, errors = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // (a^k mod M) expressed in Montgomery form
    function automatic int mont_pow(input int a, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = (r * a) % MODV;
        return (r * 16) % MODV;
    endfunction

    // Build the expected transaction list from exponent prefixes.
    task automatic plan(input int ew, input int e, input int b);
        int a, pre, n;
        exp_q.delete();
        a = (b * RINV) % MODV;
        n = 0;
        for (int i = ew - 1; i >= 0; i--) begin
            pre = e >> (i + 1);
            exp_q.push_back('{1'b0, mont_pow(a, pre), mont_pow(a, pre)});
            n++;
            if (((e >> i) & 1) == 1) begin
                exp_q.push_back('{1'b1, mont_pow(a, 2 * pre), b});
                n++;
            end
        end
        exp_res  = mont_pow(a, e);
        exp_lat  = 2 + n * (1 + L);
        exp_end  = 1;
        n_issued = 0;
        end_seen = 0;
    endtask

    task automatic kick(input bit s, input int e, input int b, input int one);
        sel = s; exponent = 4'(e); base_mont = 4'(b); one_mont = 4'(one); modulus = 4'(MODV);
        plan(s ? 2 : 4, e, b);
        @(posedge clk); #1;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 400 && end_seen == 0; i++) @(negedge clk);
        check("end_reached", end_seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_issued(input int k);
        for (int i = 0; i < 200 && n_issued < k; i++) begin
            @(posedge clk); #1;
        end
        check("reach_txn", n_issued, k);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_ctl"}, int'({busy, done, aborted, mp_in_valid}), 0);
        check({tag, "_ops"}, int'({mp_opA, mp_opB, mp_opM}), 0);
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mp_in_valid) begin
                n_issued++;
                check("txn_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    check(t.is_mul ? "mul_opA" : "sq_opA", int'(mp_opA), t.a);
                    check(t.is_mul ? "mul_opB" : "sq_opB", int'(mp_opB), t.b);
                    check("opM", int'(mp_opM), MODV);
                    check("busy_in_txn", int'(busy), 1);
                end
            end
            if (mov) last_mov_cyc = cyc;
            if (done) begin
                check("done_expected", exp_end, 1);
                check("result", int'(result), exp_res);
                last_lat = cyc - start_cyc;
                check("latency", last_lat, exp_lat);
                check("txns_left", exp_q.size(), 0);
                check("busy_at_done", int'(busy), 0);
                prev_res[sel] = exp_res;
                end_seen = 1; exp_end = 0;
            end
            if (aborted) begin
                check("abort_expected", exp_end, 2);
                check("result_kept", int'(result), prev_res[sel]);
                check("abort_after_drain", cyc, last_mov_cyc + 1);
                check("busy_at_abort", int'(busy), 0);
                end_seen = 1; exp_end = 0;
            end
        end
    end

    int vec_e[4]   = '{0, 1, 15, 5};
    int vec_res[4] = '{3, 6, 11, 5};

    initial begin
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // 2-bit exponent, e=3: S,M,S,M -> 8*16 mod 13 = 11
        kick(1'b1, 3, 6, 3);
        check("model_pin_e3", exp_res, 11);
        wait_end();
        check("dut2_result_lit", int'(result), 11);
        check("dut2_lat_lit", last_lat, 18);

        // 4-bit exponent table; e=0 is 4 squares only, e=1 ends in a multiply
        for (int v = 0; v < 4; v++) begin
            kick(1'b0, vec_e[v], 6, 3);
            check("model_pin", exp_res, vec_res[v]);
            wait_end();
            check("result_lit", int'(result), vec_res[v]);
            if (v == 0) check("lat_e0_lit", last_lat, 18);
            if (v == 1) check("lat_e1_lit", last_lat, 22);
        end

        // Abort in SQ_WAIT of the 2nd transaction: drain then aborted
        kick(1'b0, 6, 6, 3);
        wait_issued(2);
        exp_end = 2;
        exp_q.delete();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_end();
        check("abort_result_lit", int'(result), 5);
        repeat (12) @(posedge clk);
        #1 check("no_txn_after_abort", n_issued, 2);

        // Spurious response in IDLE, then a start while busy
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("spur_busy", int'(busy), 0);
        check("spur_result", int'(result), 5);
        kick(1'b0, 9, 6, 3);
        check("model_pin_e9", exp_res, 2);
        wait_issued(1);
        exponent = 4'hF; base_mont = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end();
        check("restart_ignored_lit", int'(result), 2);

        // Asynchronous reset while in MUL_WAIT, then a fresh run
        kick(1'b0, 3, 6, 3);
        wait_issued(4);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete(); exp_end = 0; prev_res[0] = 0; prev_res[1] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        kick(1'b0, 5, 6, 3);
        wait_end();
        check("after_reset_lit", int'(result), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
